// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder for the data port, backed by a
// word-organised synchronous RAM. Sub-word stores use read-modify-write.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_MERGE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [15:0]           wdata_q, wdata_d;   // only sub-word stores replay wdata
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word_q;

  logic                  accept_c;
  logic                  misalign_c;
  logic                  mem_we_c;
  logic                  mem_re_c;
  logic [IDX_W-1:0]      mem_idx_c;
  logic [31:0]           mem_wdata_c;
  logic [31:0]           merged_c;
  logic [31:0]           load_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;

  // Illegal size or misaligned halfword/word request
  always_comb begin
    misalign_c = 1'b0;
    unique case (req_size)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: misalign_c = req_addr[0];
      SZ_WORD: misalign_c = (req_addr[1:0] != 2'b00);
      SZ_ILL:  misalign_c = 1'b1;
    endcase
  end

  // Lane extraction/extension for loads and lane insertion for sub-word stores
  always_comb begin
    byte_c   = rd_word_q[{addr_q[1:0], 3'b000} +: 8];
    half_c   = rd_word_q[{addr_q[1], 4'b0000} +: 16];
    load_c   = rd_word_q;
    merged_c = rd_word_q;
    unique case (size_q)
      SZ_BYTE: begin
        load_c = uns_q ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
        merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_c = uns_q ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
        merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: begin
        load_c   = rd_word_q;
        merged_c = rd_word_q;
      end
    endcase
  end

  // Next-state, request latching, RAM control and registered output values
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    ready_d     = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_idx_c   = addr_q[ADDR_WIDTH-1:2];
    mem_wdata_c = merged_c;
    accept_c    = (state_q == S_IDLE) && req_valid && ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          if (misalign_c) begin
            state_d = S_RESP;
            valid_d = 1'b1;
            error_d = 1'b1;
            rdata_d = 32'b0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            mem_we_c    = 1'b1;
            mem_idx_c   = req_addr[ADDR_WIDTH-1:2];
            mem_wdata_c = req_wdata;
            state_d     = S_RESP;
            valid_d     = 1'b1;
            rdata_d     = 32'b0;
          end else begin
            mem_re_c  = 1'b1;
            mem_idx_c = req_addr[ADDR_WIDTH-1:2];
            state_d   = req_write ? S_MERGE : S_READ;
          end
        end
      end
      S_READ: begin
        rdata_d = load_c;
        valid_d = 1'b1;
        state_d = S_RESP;
      end
      S_MERGE: begin
        mem_we_c = 1'b1;
        rdata_d  = 32'b0;
        valid_d  = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 16'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Synchronous RAM: one write port, one registered read port, contents not reset
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      mem[mem_idx_c] <= mem_wdata_c;
    end
    if (mem_re_c) begin
      rd_word_q <= mem[mem_idx_c];
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected
// responses; a negedge monitor pops and checks data, error flag and latency.
module tb_data_mem_responder;

  localparam int unsigned AW = 9;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;

  data_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pop one expectation per response, check busy-time ready and idle error
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (resp_valid !== 1'b1 && resp_error !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_error: resp_error=%b while resp_valid=0 (cycle %0d), required 0", resp_error, cyc);
      end
      if (resp_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp: rdata=%h err=%b at cycle %0d, no response expected", resp_rdata, resp_error, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (resp_rdata !== mon_e.rdata || resp_error !== mon_e.err || cyc != mon_e.due) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                     mon_e.name, resp_rdata, resp_error, cyc, mon_e.rdata, mon_e.err, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        mon_e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: no response by cycle %0d, required rdata=%h err=%b", mon_e.name, cyc, mon_e.rdata, mon_e.err);
      end
      if (sb.size() > 0 && cyc > sb[0].acc && req_ready === 1'b1) begin
        miscompares++;
        $display("FAIL ready_busy: req_ready=1 at cycle %0d while %s in flight, required 0", cyc, sb[0].name);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Present a request at the current negedge; returns at the negedge after its accept edge
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat,
                       input string nm, input bit track);
    exp_t e;
    int   waits;
    waits        = 0;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    while (req_ready !== 1'b1 && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_accept: req_ready=%b after %0d cycles, required 1", nm, req_ready, waits);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e.rdata = er;
      e.err   = ee;
      e.acc   = cyc;
      e.due   = cyc + lat;
      e.name  = nm;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  // Drop the request and let outstanding responses come back
  task automatic drain();
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_wdata    = 32'hA5A5_A5A5;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = 32'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset");

    // Word store then loads of every lane flavour
    issue(1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0, 0, 1, "st_w_010", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'hDEADBEEF, 0, 2, "ld_w_010", 1); drain();
    issue(0, 2'b00, 0, 9'h013, 32'h0, 32'hFFFFFFDE, 0, 2, "ld_b_013_s", 1); drain();
    issue(0, 2'b00, 1, 9'h013, 32'h0, 32'h000000DE, 0, 2, "ld_b_013_u", 1); drain();
    issue(0, 2'b00, 0, 9'h010, 32'h0, 32'hFFFFFFEF, 0, 2, "ld_b_010_s", 1); drain();
    issue(0, 2'b00, 1, 9'h011, 32'h0, 32'h000000BE, 0, 2, "ld_b_011_u", 1); drain();
    issue(0, 2'b01, 0, 9'h010, 32'h0, 32'hFFFFBEEF, 0, 2, "ld_h_010_s", 1); drain();
    issue(0, 2'b01, 1, 9'h012, 32'h0, 32'h0000DEAD, 0, 2, "ld_h_012_u", 1); drain();

    // Read-modify-write; upper wdata bits must not leak into the word
    issue(1, 2'b00, 0, 9'h011, 32'hAAAAAA55, 32'h0, 0, 2, "st_b_011", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'hDEAD55EF, 0, 2, "ld_w_after_sb", 1); drain();
    issue(1, 2'b01, 0, 9'h012, 32'hFFFF1234, 32'h0, 0, 2, "st_h_012", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'h123455EF, 0, 2, "ld_w_after_sh", 1); drain();

    // Errors: no array access, one-cycle latency, zero data
    issue(1, 2'b10, 0, 9'h012, 32'hFFFFFFFF, 32'h0, 1, 1, "err_st_w_012", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'h123455EF, 0, 2, "ld_w_after_err1", 1); drain();
    issue(0, 2'b01, 0, 9'h011, 32'h0, 32'h0, 1, 1, "err_ld_h_011", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'h123455EF, 0, 2, "ld_w_after_err2", 1); drain();
    issue(1, 2'b11, 0, 9'h010, 32'h0BADF00D, 32'h0, 1, 1, "err_st_size11", 1); drain();
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'h123455EF, 0, 2, "ld_w_after_err3", 1); drain();

    // Top word of the array
    issue(1, 2'b10, 0, 9'h1FC, 32'hCAFEF00D, 32'h0, 0, 1, "st_w_top", 1); drain();
    issue(0, 2'b00, 1, 9'h1FF, 32'h0, 32'h000000CA, 0, 2, "ld_b_top_u", 1); drain();
    issue(0, 2'b10, 0, 9'h1FC, 32'h0, 32'hCAFEF00D, 0, 2, "ld_w_top", 1); drain();

    // Back-to-back with req_valid held high
    issue(1, 2'b10, 0, 9'h020, 32'h11223344, 32'h0, 0, 1, "b2b_st_w", 1);
    issue(0, 2'b00, 0, 9'h020, 32'h0, 32'h00000044, 0, 2, "b2b_ld_b", 1);
    issue(1, 2'b01, 0, 9'h022, 32'h0000BEEF, 32'h0, 0, 2, "b2b_st_h", 1);
    issue(0, 2'b10, 0, 9'h020, 32'h0, 32'hBEEF3344, 0, 2, "b2b_ld_w", 1);
    drain();

    // Reset during the MERGE cycle of a byte store
    issue(1, 2'b00, 0, 9'h010, 32'h00000099, 32'h0, 0, 2, "rst_st_b", 0);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset");
    issue(0, 2'b10, 0, 9'h010, 32'h0, 32'h123455EF, 0, 2, "ld_w_after_reset", 1); drain();

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
